// File: rtl/chess_timer.sv
`default_nettype none
// ============================================================================
// Module  : chess_timer
// Brief   : Two-player chess clock; MM:SS BCD countdown per player, 1 Hz tick.
// Revision: 1.0 - initial release
// ============================================================================
module chess_timer #(
    parameter int INIT_MIN = 5,
    parameter int INIT_SEC = 0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic [3:0] a_digit0,
    output logic [3:0] a_digit1,
    output logic [3:0] a_digit2,
    output logic [3:0] a_digit3,
    output logic [3:0] b_digit0,
    output logic [3:0] b_digit1,
    output logic [3:0] b_digit2,
    output logic [3:0] b_digit3,
    output logic [1:0] active,
    output logic       flag_a,
    output logic       flag_b
);

    localparam logic [15:0] c_INIT_TIME = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                           4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};
    localparam logic [15:0] c_ZERO_TIME = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_A  = 3'd1,
        S_RUN_B  = 3'd2,
        S_FLAG_A = 3'd3,
        S_FLAG_B = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] w_a_nxt;
    logic [15:0] w_b_nxt;
    logic [15:0] w_a_dec;
    logic [15:0] w_b_dec;
    logic [1:0]  r_active;
    logic [1:0]  w_active_nxt;
    logic        r_flag_a;
    logic        r_flag_b;
    logic        w_flag_a_nxt;
    logic        w_flag_b_nxt;

    // One-second BCD decrement with borrow chain; minutes tens never wraps
    // because expiry stops the count at 00:00.
    function automatic logic [15:0] f_bcd_dec(input logic [15:0] t);
        logic [3:0] d0, d1, d2, d3;
        logic       b0, b1, b2;
        d0 = t[3:0];
        d1 = t[7:4];
        d2 = t[11:8];
        d3 = t[15:12];
        b0 = (d0 == 4'd0);
        d0 = b0 ? 4'd9 : d0 - 4'd1;
        b1 = b0 && (d1 == 4'd0);
        if (b0) d1 = (d1 == 4'd0) ? 4'd5 : d1 - 4'd1;
        b2 = b1 && (d2 == 4'd0);
        if (b1) d2 = (d2 == 4'd0) ? 4'd9 : d2 - 4'd1;
        if (b2 && d3 != 4'd0) d3 = d3 - 4'd1;
        return {d3, d2, d1, d0};
    endfunction

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_state  <= S_IDLE;
            r_a      <= c_INIT_TIME;
            r_b      <= c_INIT_TIME;
            r_active <= 2'b00;
            r_flag_a <= 1'b0;
            r_flag_b <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_active <= w_active_nxt;
            r_flag_a <= w_flag_a_nxt;
            r_flag_b <= w_flag_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_a_dec     = f_bcd_dec(r_a);
        w_b_dec     = f_bcd_dec(r_b);
        if (CE) begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_RUN_A;
                end
                S_RUN_A: begin
                    // Decrement lands first; expiry then beats a turn switch.
                    if (tick) w_a_nxt = w_a_dec;
                    if (tick && w_a_dec == c_ZERO_TIME) w_state_nxt = S_FLAG_A;
                    else if (btn_a)                     w_state_nxt = S_RUN_B;
                end
                S_RUN_B: begin
                    if (tick) w_b_nxt = w_b_dec;
                    if (tick && w_b_dec == c_ZERO_TIME) w_state_nxt = S_FLAG_B;
                    else if (btn_b)                     w_state_nxt = S_RUN_A;
                end
                S_FLAG_A, S_FLAG_B: begin
                    if (start) begin
                        w_state_nxt = S_IDLE;
                        w_a_nxt     = c_INIT_TIME;
                        w_b_nxt     = c_INIT_TIME;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_active_nxt = 2'b00;
        w_flag_a_nxt = 1'b0;
        w_flag_b_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN_A:  w_active_nxt = 2'b01;
            S_RUN_B:  w_active_nxt = 2'b10;
            S_FLAG_A: w_flag_a_nxt = 1'b1;
            S_FLAG_B: w_flag_b_nxt = 1'b1;
            default:  w_active_nxt = 2'b00;
        endcase
    end

    assign a_digit0 = r_a[3:0];
    assign a_digit1 = r_a[7:4];
    assign a_digit2 = r_a[11:8];
    assign a_digit3 = r_a[15:12];
    assign b_digit0 = r_b[3:0];
    assign b_digit1 = r_b[7:4];
    assign b_digit2 = r_b[11:8];
    assign b_digit3 = r_b[15:12];
    assign active   = r_active;
    assign flag_a   = r_flag_a;
    assign flag_b   = r_flag_b;

endmodule
`default_nettype wire

// File: tb/tb_chess_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_chess_timer
// Brief   : Scoreboard bench; three builds (05:00, 10:00, 00:02) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chess_timer;

    logic CLK = 1'b0;
    logic CLR, CE, tick, start, btn_a, btn_b;

    logic [3:0] ad0 [3], ad1 [3], ad2 [3], ad3 [3];
    logic [3:0] bd0 [3], bd1 [3], bd2 [3], bd3 [3];
    logic [1:0] act [3];
    logic       fa [3], fb [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        logic [35:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    chess_timer #(.INIT_MIN(5), .INIT_SEC(0)) u_def (
        .CLK(CLK), .CLR(CLR), .CE(CE), .tick(tick), .start(start), .btn_a(btn_a), .btn_b(btn_b),
        .a_digit0(ad0[0]), .a_digit1(ad1[0]), .a_digit2(ad2[0]), .a_digit3(ad3[0]),
        .b_digit0(bd0[0]), .b_digit1(bd1[0]), .b_digit2(bd2[0]), .b_digit3(bd3[0]),
        .active(act[0]), .flag_a(fa[0]), .flag_b(fb[0]));

    chess_timer #(.INIT_MIN(10), .INIT_SEC(0)) u_ten (
        .CLK(CLK), .CLR(CLR), .CE(CE), .tick(tick), .start(start), .btn_a(btn_a), .btn_b(btn_b),
        .a_digit0(ad0[1]), .a_digit1(ad1[1]), .a_digit2(ad2[1]), .a_digit3(ad3[1]),
        .b_digit0(bd0[1]), .b_digit1(bd1[1]), .b_digit2(bd2[1]), .b_digit3(bd3[1]),
        .active(act[1]), .flag_a(fa[1]), .flag_b(fb[1]));

    chess_timer #(.INIT_MIN(0), .INIT_SEC(2)) u_two (
        .CLK(CLK), .CLR(CLR), .CE(CE), .tick(tick), .start(start), .btn_a(btn_a), .btn_b(btn_b),
        .a_digit0(ad0[2]), .a_digit1(ad1[2]), .a_digit2(ad2[2]), .a_digit3(ad3[2]),
        .b_digit0(bd0[2]), .b_digit1(bd1[2]), .b_digit2(bd2[2]), .b_digit3(bd3[2]),
        .active(act[2]), .flag_a(fa[2]), .flag_b(fb[2]));

    // Expected output vector from decimal times: {A MM:SS, B MM:SS, active, flag_a, flag_b}
    function automatic logic [35:0] mk(input int am, input int asec, input int bm, input int bsec,
                                       input logic [1:0] ac, input logic f_a, input logic f_b);
        return {4'(am / 10), 4'(am % 10), 4'(asec / 10), 4'(asec % 10),
                4'(bm / 10), 4'(bm % 10), 4'(bsec / 10), 4'(bsec % 10), ac, f_a, f_b};
    endfunction

    function automatic logic [35:0] obs(input int i);
        return {ad3[i], ad2[i], ad1[i], ad0[i], bd3[i], bd2[i], bd1[i], bd0[i], act[i], fa[i], fb[i]};
    endfunction

    // One clock of stimulus; inputs return to idle levels just after the edge.
    task automatic step(input logic t, input logic s, input logic ba, input logic bb,
                        input logic ce = 1'b1, input logic clr = 1'b1);
        tick = t; start = s; btn_a = ba; btn_b = bb; CE = ce; CLR = clr;
        @(posedge CLK);
        #1;
        tick = 1'b0; start = 1'b0; btn_a = 1'b0; btn_b = 1'b0; CE = 1'b1; CLR = 1'b1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        exp_t e;
        step(1, 0, 0, 0, 0, 0);   // CE low and tick high: reset still wins
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b00, 0, 0), "reset_def"});
        sb.push_back('{1, mk(10, 0, 10, 0, 2'b00, 0, 0), "reset_ten"});
        sb.push_back('{2, mk(0, 2, 0, 2, 2'b00, 0, 0), "reset_two"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 1, 1); step(1, 0, 0, 0);
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b00, 0, 0), "idle_tick_def"});
        sb.push_back('{2, mk(0, 2, 0, 2, 2'b00, 0, 0), "idle_tick_two"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_count_switch();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0);
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b01, 0, 0), "start_def"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1);   // start and btn_b ignored in RUN_A
        sb.push_back('{0, mk(4, 57, 5, 0, 2'b01, 0, 0), "count_a_def"});
        sb.push_back('{1, mk(9, 57, 10, 0, 2'b01, 0, 0), "count_a_ten"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(0, 0, 1, 0);
        step(1, 0, 0, 0); step(1, 0, 1, 0);             // btn_a ignored in RUN_B
        sb.push_back('{0, mk(4, 57, 4, 58, 2'b10, 0, 0), "count_b_def"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_borrow();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        sb.push_back('{1, mk(9, 59, 10, 0, 2'b01, 0, 0), "borrow_10_00"});
        sb.push_back('{0, mk(4, 59, 5, 0, 2'b01, 0, 0), "borrow_05_00"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_expiry();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        sb.push_back('{2, mk(0, 1, 0, 2, 2'b01, 0, 0), "pre_expiry"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 1, 0);
        sb.push_back('{2, mk(0, 0, 0, 2, 2'b00, 1, 0), "expiry_a"});
        sb.push_back('{0, mk(4, 58, 5, 0, 2'b10, 0, 0), "switch_after_tick"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 0, 0); step(0, 0, 0, 1); step(1, 0, 1, 1);
        sb.push_back('{2, mk(0, 0, 0, 2, 2'b00, 1, 0), "flag_a_frozen"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(0, 1, 0, 0);
        sb.push_back('{2, mk(0, 2, 0, 2, 2'b00, 0, 0), "flag_ack"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);                                // idle after ack: ticks ignored, start runs A
        sb.push_back('{2, mk(0, 2, 0, 2, 2'b01, 0, 0), "ack_then_start"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_expiry_b();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0); step(0, 0, 1, 0);
        step(1, 0, 0, 0); step(1, 0, 0, 1);
        sb.push_back('{2, mk(0, 2, 0, 0, 2'b00, 0, 1), "expiry_b"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_ce_gating();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b01, 0, 0), "ce_low_hold"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 0, 0);
        sb.push_back('{0, mk(4, 59, 5, 0, 2'b01, 0, 0), "ce_high_resume"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0);
        tick = 1'b1;                                     // held high for 3 edges
        repeat (3) @(posedge CLK);
        #1 tick = 1'b0;
        sb.push_back('{0, mk(4, 57, 5, 0, 2'b01, 0, 0), "held_tick"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    task automatic test_midgame_reset();
        exp_t e;
        do_reset();
        step(0, 1, 0, 0); step(0, 0, 1, 0);
        for (int i = 0; i < 50; i++) step(1, 0, 0, 0);
        sb.push_back('{0, mk(5, 0, 4, 10, 2'b10, 0, 0), "b_at_04_10"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        do_reset();
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b00, 0, 0), "midgame_reset"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        sb.push_back('{0, mk(5, 0, 5, 0, 2'b01, 0, 0), "reset_to_idle"});
        @(negedge CLK);
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs(e.inst) !== e.v) begin failures++; $display("FAIL %s: got %h want %h", e.name, obs(e.inst), e.v); end
        end
    endtask

    initial begin
        CLR = 1'b0; CE = 1'b1; tick = 1'b0; start = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        test_reset();
        test_count_switch();
        test_borrow();
        test_expiry();
        test_expiry_b();
        test_ce_gating();
        test_back_to_back();
        test_midgame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chess_timer.md
# chess_timer

Two-player chess-clock countdown core. Holds each player's remaining time as four BCD digits (MM:SS), counts down the active player's time on a 1 Hz tick, switches turns on player buttons and flags a player whose time expires. It sits upstream of the seven-segment decoder: its digit outputs feed the decoder's `digit0..digit3` inputs, one decoder per player.

## Interface
Parameters:
- `INIT_MIN`, default 5: starting minutes for both players; legal range 0..99.
- `INIT_SEC`, default 0: starting seconds for both players; legal range 0..59. `INIT_MIN:INIT_SEC` must be non-zero.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `CLR`  in  1  reset, synchronous, active-low. Sampled on rising `CLK`; `CLR`=0 resets.
- `CE`  in  1  clock enable. When 0, all state holds and every other input is ignored, including `tick`.
- `tick`  in  1  one-cycle pulse at 1 Hz.
- `start`  in  1  one-cycle pulse; starts a game, or acknowledges a flag.
- `btn_a`  in  1  one-cycle pulse; player A ends its move.
- `btn_b`  in  1  one-cycle pulse; player B ends its move.
- `a_digit0..a_digit3`  out  4 each  player A time in BCD: digit0 = seconds units, digit1 = seconds tens, digit2 = minutes units, digit3 = minutes tens.
- `b_digit0..b_digit3`  out  4 each  player B time, same digit layout.
- `active`  out  2  01 = A running, 10 = B running, 00 = otherwise.
- `flag_a`, `flag_b`  out  1 each  the named player's time expired.

## Operation
- States: IDLE, RUN_A, RUN_B, FLAG_A, FLAG_B.
- **Reset** (`CLR`=0): state goes to IDLE. Both players load `INIT_MIN:INIT_SEC`. `active`=00, `flag_a`=`flag_b`=0. Reset takes priority over `CE`.
- **IDLE**: `start` moves to RUN_A (A moves first). `tick`, `btn_a` and `btn_b` are ignored.
- **RUN_A**:
  - `tick` decrements A by 1 s.
  - `btn_a` moves to RUN_B.
  - `btn_b` and `start` are ignored.
- **RUN_B**: mirror of RUN_A with A and B swapped.
- **Tick and button in the same cycle**: the decrement is applied first, then the turn switches.
- **Expiry**: if a decrement takes the running player from 00:01 to 00:00, the next state is FLAG_x in that same edge. Expiry overrides a simultaneous button press.
- **FLAG_A / FLAG_B**:
  - The corresponding flag is 1 and `active`=00.
  - Both times freeze; `tick` and the buttons are ignored.
  - `start` reloads both players to the initial time, clears the flag and moves to IDLE.
- **BCD decrement** (borrow chain):
  - Seconds units 0 goes to 9 and borrows.
  - Seconds tens 0 goes to 5 and borrows.
  - Minutes units 0 goes to 9 and borrows.
  - Minutes tens decrements.
  - Examples: 10:00 goes to 09:59; 01:00 goes to 00:59.
- All digits are always valid BCD. Seconds tens is never above 5.
- The idle player's time never changes.

## Timing
- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N.
- Latency from input to output is one cycle.
- `tick` is counted once per cycle in which it is high with `CE`=1. A `tick` held high for k cycles decrements k times.
- `CE`=0 on a cycle with a `tick` loses that tick; no catch-up.
- Reset mid-game behaves the same as reset from power-up: the full reset values apply after one edge.
- Outputs during reset: digits equal the initial time in BCD. With the defaults: `a_digit3..0` = 0,5,0,0 and `b_digit3..0` = 0,5,0,0.

## Test plan
- **Reset values**: with defaults, assert `CLR`=0 for 1 cycle, then release. Required: both players read 05:00, `active`=00, both flags 0. Tick pulses in IDLE do not change the digits.
- **Count and switch**:
  - Pulse `start`, then apply 3 ticks. Required: A reads 04:57, B reads 05:00, `active`=01.
  - Pulse `btn_a`, then apply 2 ticks. Required: A holds 04:57, B reads 04:58, `active`=10.
- **Borrow chain**: build with `INIT_MIN`=10, `INIT_SEC`=0. Pulse `start`, then 1 tick. Required: A reads 09:59 (digits 0,9,5,9).
- **Expiry and simultaneous press**: build with `INIT_MIN`=0, `INIT_SEC`=2. Pulse `start`, apply 1 tick, then a second tick in the same cycle as `btn_a`. Required: A reads 00:00, `flag_a`=1, `active`=00. Further ticks and buttons leave all outputs unchanged.
- **Flag acknowledge and CE gating**:
  - From FLAG_A, pulse `start`. Required: IDLE, both players at the initial time, flag cleared.
  - In RUN_A with `CE`=0, apply 4 ticks and `btn_a`. Required: no change to any output.
- **Mid-game reset**: in RUN_B with B at 04:10, drive `CLR`=0 for one edge. Required: both players at 05:00, `active`=00, state IDLE.
